// File: rtl/nn_pkg.sv
// Shared definitions for the activation scheduler and the neuron-side logic:
// width helpers, the FSM encoding and the saturating ReLU rule.
package nn_pkg;

    // Widest accumulator / result the sat_relu() helper can handle.
    localparam int ACC_MAX = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Accumulator width: full product width plus guard bits.
    function automatic int acc_width(input int data_w, input int ext_w);
        return 2 * data_w + ext_w;
    endfunction

    // Width of a neuron index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Saturating ReLU. x holds an acc_w-bit signed accumulator, zero-extended
    // to ACC_MAX. Negative values clamp to 0; anything with a set bit in the
    // integer/guard field above the output slice clamps to the largest
    // positive output; otherwise the fixed-point window is passed through.
    // Only the low data_w bits of the result are meaningful.
    function automatic logic [ACC_MAX-1:0] sat_relu(
        input logic [ACC_MAX-1:0] x,
        input int                 acc_w,
        input int                 data_w,
        input int                 wint_w,
        input int                 ext_w
    );
        logic [ACC_MAX-1:0] r;
        logic               sat;
        int                 src;
        r   = '0;
        sat = 1'b0;
        src = 0;
        for (int i = 0; i < ACC_MAX; i++) begin
            if ((i >= acc_w - 1 - (wint_w + ext_w)) && (i < acc_w)) begin
                sat = sat | x[i];
            end
        end
        if (x[acc_w-1]) begin
            r = '0;
        end else if (sat) begin
            for (int j = 0; j < ACC_MAX; j++) begin
                if (j < data_w - 1) begin
                    r[j] = 1'b1;
                end
            end
        end else begin
            for (int j = 0; j < ACC_MAX; j++) begin
                src = data_w - wint_w + j;
                if ((j < data_w) && (src >= 0) && (src < ACC_MAX)) begin
                    r[j] = x[src];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after ptr,
// wrapping around, and reports it as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    // Rotating priority search starting at ptr; nothing is granted when en is low.
    always_comb begin
        int cand;
        cand      = 0;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                cand = (int'(ptr) + k) % N;
                if (!gnt_valid && req[cand]) begin
                    gnt_valid = 1'b1;
                    gnt[cand] = 1'b1;
                    gnt_idx   = IW'(cand);
                end
            end
        end
    end

endmodule

// File: rtl/relu_share_scheduler.sv
// Shares one registered ReLU/saturation stage among the accumulators of a
// layer. Accepted values are activated, buffered in a small FIFO with their
// neuron index and streamed out; layer_done marks the last result popped.
//
// Handshakes: a transfer happens on any cycle where valid and ready are both
// high (in_valid[i]&in_ready[i] upstream, out_valid&out_ready downstream).
// in_ready never depends on the value of in_data, and out_valid/out_data/
// out_idx hold steady while out_valid is high and out_ready is low.
module relu_share_scheduler
    import nn_pkg::*;
#(
    parameter  int NUM_NEURONS    = 8,
    parameter  int dataWidth      = 16,
    parameter  int weightIntWidth = 4,
    parameter  int IntWidthExtend = 10,
    parameter  int FIFO_DEPTH     = 4,
    localparam int ACC_W          = acc_width(dataWidth, IntWidthExtend),
    localparam int IDX_W          = idx_width(NUM_NEURONS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         layer_start,
    input  logic [NUM_NEURONS-1:0]       in_valid,
    input  logic [NUM_NEURONS*ACC_W-1:0] in_data,
    output logic [NUM_NEURONS-1:0]       in_ready,
    output logic                         out_valid,
    output logic [dataWidth-1:0]         out_data,
    output logic [IDX_W-1:0]             out_idx,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         layer_done
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int PC_W = IDX_W + 1;

    state_e                 state_q, state_d;
    logic [NUM_NEURONS-1:0] served_q, served_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [PC_W-1:0]        pop_cnt_q, pop_cnt_d;
    logic                   layer_done_q, layer_done_d;

    logic                   stage_valid_q, stage_valid_d;
    logic [dataWidth-1:0]   stage_data_q, stage_data_d;
    logic [IDX_W-1:0]       stage_idx_q, stage_idx_d;

    logic [dataWidth-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [dataWidth-1:0]   fifo_data_d [FIFO_DEPTH];
    logic [IDX_W-1:0]       fifo_idx_q  [FIFO_DEPTH];
    logic [IDX_W-1:0]       fifo_idx_d  [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          fifo_count_q, fifo_count_d;

    logic [NUM_NEURONS-1:0] req;
    logic                   grant_en;
    logic [NUM_NEURONS-1:0] gnt;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   gnt_valid;
    logic [ACC_MAX-1:0]     x_ext;
    logic [ACC_MAX-1:0]     act_full;
    logic [dataWidth-1:0]   act;
    logic                   push;
    logic                   pop;

    // Eligible requesters: valid and not yet served this layer. A grant also
    // needs a FIFO slot that is not already claimed by the activation stage.
    always_comb begin
        req      = in_valid & ~served_q;
        grant_en = (state_q == ST_RUN) &&
                   ((int'(fifo_count_q) + int'(stage_valid_q)) < FIFO_DEPTH);
    end

    rr_arbiter #(
        .N  (NUM_NEURONS),
        .IW (IDX_W)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .en        (grant_en),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Activation of the granted accumulator, registered in the stage below.
    always_comb begin
        x_ext    = ACC_MAX'(in_data[gnt_idx*ACC_W +: ACC_W]);
        act_full = sat_relu(x_ext, ACC_W, dataWidth, weightIntWidth, IntWidthExtend);
        act      = dataWidth'(act_full);
    end

    // Output side of the FIFO.
    always_comb begin
        out_valid = (fifo_count_q != '0);
        out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
        out_idx   = out_valid ? fifo_idx_q[rd_ptr_q]  : '0;
        pop       = out_valid & out_ready;
        push      = stage_valid_q;
        in_ready  = gnt;
        busy      = (state_q != ST_IDLE);
        layer_done = layer_done_q;
    end

    // Layer FSM, served mask, round-robin pointer and pop counter.
    always_comb begin
        state_d      = state_q;
        served_d     = served_q;
        ptr_d        = ptr_q;
        pop_cnt_d    = pop_cnt_q;
        layer_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (layer_start) begin
                    state_d   = ST_RUN;
                    served_d  = '0;
                    pop_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (&served_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (int'(pop_cnt_q) == NUM_NEURONS) begin
                    state_d      = ST_IDLE;
                    layer_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (gnt_valid) begin
            served_d[gnt_idx] = 1'b1;
            ptr_d = (int'(gnt_idx) == NUM_NEURONS - 1) ? '0 : gnt_idx + 1'b1;
        end
        if (pop) begin
            pop_cnt_d = pop_cnt_q + 1'b1;
        end
    end

    // Activation stage load and FIFO bookkeeping; push and pop may coincide.
    always_comb begin
        stage_valid_d = gnt_valid;
        stage_data_d  = act;
        stage_idx_d   = gnt_idx;
        fifo_data_d   = fifo_data_q;
        fifo_idx_d    = fifo_idx_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_count_d  = fifo_count_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = stage_data_q;
            fifo_idx_d[wr_ptr_q]  = stage_idx_q;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + 1'b1;
            2'b01:   fifo_count_d = fifo_count_q - 1'b1;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            served_q      <= '0;
            ptr_q         <= '0;
            pop_cnt_q     <= '0;
            layer_done_q  <= 1'b0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            stage_idx_q   <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_idx_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            served_q      <= served_d;
            ptr_q         <= ptr_d;
            pop_cnt_q     <= pop_cnt_d;
            layer_done_q  <= layer_done_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            stage_idx_q   <= stage_idx_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_count_q  <= fifo_count_d;
            fifo_data_q   <= fifo_data_d;
            fifo_idx_q    <= fifo_idx_d;
        end
    end

endmodule

// File: tb/tb_relu_share_scheduler.sv
// Directed bench for relu_share_scheduler: hand-computed activation table,
// expected-result queue checked on every output pop, per-layer grant counts.
module tb_relu_share_scheduler;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int AW = 42;
    localparam int IW = 3;
    localparam int W  = IW + DW;

    logic            clk = 1'b0;
    logic            rst;
    logic            layer_start;
    logic [N-1:0]    in_valid;
    logic [N*AW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_idx;
    logic            out_ready;
    logic            busy;
    logic            layer_done;

    // clock / reset block
    always #5 clk = ~clk;

    relu_share_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .layer_start (layer_start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_ready   (out_ready),
        .busy        (busy),
        .layer_done  (layer_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_pop_cyc = 0;
    int gcnt [N];

    logic [W-1:0]  exp_q [$];
    logic [AW-1:0] x_tab [N];
    logic [DW-1:0] y_tab [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst) begin
            if (layer_start && !busy) begin
                for (int i = 0; i < N; i++) gcnt[i] = 0;
            end
            if (in_ready != '0) check("grant onehot", 64'($countones(in_ready) <= 1), 1);
            for (int i = 0; i < N; i++) begin
                if (in_valid[i] && in_ready[i]) gcnt[i]++;
            end
            if (out_valid && out_ready) begin
                last_pop_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("pop with empty scoreboard", 64'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("pop idx/data", {out_idx, out_data}, e);
                end
            end
            if (layer_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int i);
        exp_q.push_back({IW'(i), y_tab[i]});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        layer_start = 1'b0;
        in_valid = '0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic finish_layer(input string tag);
        int start;
        start = done_cnt;
        for (int k = 0; k < 300 && done_cnt == start; k++) step();
        repeat (4) step();
        check({tag, " layer_done pulses"}, 64'(done_cnt - start), 1);
        check({tag, " scoreboard drained"}, 64'(exp_q.size()), 0);
        for (int i = 0; i < N; i++) check({tag, " grants per neuron"}, 64'(gcnt[i]), 1);
        check({tag, " idle after layer"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] onehot;
        int d0;
        // activation table: x and hand-computed result (slice x[27:12], sat on x[41:27])
        x_tab[0] = 42'h000_0800_0000; y_tab[0] = 16'h7FFF; // saturates via bit 27
        x_tab[1] = 42'h200_0000_0000; y_tab[1] = 16'h0000; // negative
        x_tab[2] = 42'h000_0000_0000; y_tab[2] = 16'h0000; // zero
        x_tab[3] = 42'h000_0123_4000; y_tab[3] = 16'h1234;
        x_tab[4] = 42'h000_0765_4000; y_tab[4] = 16'h7654;
        x_tab[5] = 42'h000_07FF_F000; y_tab[5] = 16'h7FFF; // largest unsaturated
        x_tab[6] = 42'h000_0000_1FFF; y_tab[6] = 16'h0001; // fraction truncated
        x_tab[7] = 42'h3FF_FFFF_FFFF; y_tab[7] = 16'h0000; // -1
        for (int i = 0; i < N; i++) in_data[i*AW +: AW] = x_tab[i];
        rst = 1'b1;
        layer_start = 1'b0;
        in_valid = '0;
        out_ready = 1'b1;

        // reset state
        do_reset();
        #1;
        check("reset in_ready", in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_idx", out_idx, 0);
        check("reset busy", busy, 0);
        check("reset layer_done", layer_done, 0);

        // single neuron n3: grant at T, result at T+2; then the rest of the layer
        layer_start = 1'b1;
        in_valid = 8'h08;
        #1;
        check("t1 no grant in idle", in_ready, 0);
        push_exp(3);
        step();
        layer_start = 1'b0;
        #1;
        check("t1 grant n3", in_ready, 8'h08);
        check("t1 busy", busy, 1);
        step();
        #1;
        check("t1 no regrant", in_ready, 0);
        check("t1 out_valid T+1", out_valid, 0);
        step();
        #1;
        check("t1 out_valid T+2", out_valid, 1);
        check("t1 out_data", out_data, 16'h1234);
        check("t1 out_idx", out_idx, 3);
        push_exp(4); push_exp(5); push_exp(6); push_exp(7);
        push_exp(0); push_exp(1); push_exp(2);
        in_valid = 8'hFF;
        finish_layer("t1");

        // all valid, free-flowing output: grants 0..7 back to back
        do_reset();
        layer_start = 1'b1;
        step();
        layer_start = 1'b0;
        in_valid = 8'hFF;
        for (int k = 0; k < N; k++) push_exp(k);
        for (int k = 0; k < N; k++) begin
            #1;
            onehot = 8'd1 << k;
            check("t3 consecutive grant", in_ready, onehot);
            step();
        end
        finish_layer("t3");
        check("t3 layer_done 2 cycles after last pop", 64'(done_cyc - last_pop_cyc), 2);

        // stalled output: FIFO plus stage fill after 4 grants
        do_reset();
        out_ready = 1'b0;
        layer_start = 1'b1;
        step();
        layer_start = 1'b0;
        in_valid = 8'hFF;
        for (int k = 0; k < N; k++) push_exp(k);
        for (int k = 0; k < N; k++) begin
            #1;
            onehot = (k < 4) ? (8'd1 << k) : 8'd0;
            check("t4 grant under stall", in_ready, onehot);
            if (k >= 5) begin
                check("t4 stalled out_valid", out_valid, 1);
                check("t4 stalled out_data", out_data, y_tab[0]);
                check("t4 stalled out_idx", out_idx, 0);
            end
            step();
        end
        out_ready = 1'b1;
        finish_layer("t4");

        // n5 held valid after acceptance; layer_start during RUN ignored
        do_reset();
        layer_start = 1'b1;
        in_valid = 8'h20;
        step();
        layer_start = 1'b0;
        #1;
        check("t5 grant n5", in_ready, 8'h20);
        push_exp(5);
        step();
        #1;
        check("t5 n5 not regranted", in_ready, 0);
        layer_start = 1'b1;
        step();
        layer_start = 1'b0;
        #1;
        check("t5 n5 not regranted after restart", in_ready, 0);
        check("t5 still busy", busy, 1);
        push_exp(6); push_exp(7); push_exp(0); push_exp(1);
        push_exp(2); push_exp(3); push_exp(4);
        in_valid = 8'hFF;
        finish_layer("t5");

        // reset in DRAIN with two results buffered, then a fresh layer
        do_reset();
        layer_start = 1'b1;
        step();
        layer_start = 1'b0;
        in_valid = 8'hFF;
        for (int k = 0; k < N; k++) push_exp(k);
        repeat (8) step();
        out_ready = 1'b0;
        step();
        #1;
        check("t6 buffered out_valid", out_valid, 1);
        check("t6 head is n6", out_idx, 6);
        check("t6 busy in drain", busy, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("t6 out_valid after rst", out_valid, 0);
        check("t6 busy after rst", busy, 0);
        check("t6 layer_done after rst", layer_done, 0);
        check("t6 in_ready after rst", in_ready, 0);
        d0 = done_cnt;
        out_ready = 1'b1;
        repeat (5) step();
        check("t6 no layer_done after rst", 64'(done_cnt - d0), 0);
        for (int k = 0; k < N; k++) push_exp(k);
        layer_start = 1'b1;
        step();
        layer_start = 1'b0;
        finish_layer("t6 fresh layer");

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
